// File: rtl/elastic_pkg.sv
// Shared types for the elastic pipeline register.
// Contents: elastic_state_t (per-stage fill state) and state_count(), which maps
// a stage state to the number of entries it holds.
package elastic_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } elastic_state_t;

  // Entries held by a stage in the given state.
  function automatic logic [1:0] state_count(input elastic_state_t s);
    case (s)
      ONE:     state_count = 2'd1;
      FULL:    state_count = 2'd2;
      default: state_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_stage.sv
// One elastic stage: a main register plus a skid register.
// Upstream ready is a registered decode of the fill state, so no ready signal
// passes combinationally from i_ready to o_ready.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_flush           synchronous clear of the stage
//   i_valid/o_ready   upstream handshake, i_data upstream payload
//   o_valid/i_ready   downstream handshake, o_data downstream payload (main)
//   o_state           current fill state, used for occupancy
module skid_stage
  import elastic_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output elastic_state_t   o_state
);

  elastic_state_t   r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = i_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & i_ready;

  // Fill-state machine; ready/valid are updated together with the state so
  // they always equal the decode of the stored state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (i_flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_state     <= ONE;
            r_out_valid <= 1'b1;
            r_main      <= i_data;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= i_data;
          end else if (w_in_xfer) begin
            // Downstream stalled: park the new word in the skid register.
            r_state    <= FULL;
            r_in_ready <= 1'b0;
            r_skid     <= i_data;
          end else if (w_out_xfer) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            r_state    <= ONE;
            r_in_ready <= 1'b1;
            r_main     <= r_skid;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_main;
  assign o_state = r_state;

endmodule

// File: rtl/elastic_pipeline_register.sv
// Chain of STAGES elastic skid stages with a valid/ready handshake and a
// synchronous flush. Stage k's downstream side feeds stage k+1's upstream side.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous clear of all stages
//   in_valid/in_ready       upstream handshake, in_data upstream payload
//   out_valid/out_ready     downstream handshake, out_data downstream payload
//   occupancy               total entries held across all stages
module elastic_pipeline_register
  import elastic_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

  localparam int unsigned OCC_W = $clog2(2*STAGES+1);

  if (STAGES < 1) begin : g_bad_stages
    $error("elastic_pipeline_register: STAGES must be at least 1");
  end

  logic             w_valid [STAGES+1];
  logic             w_ready [STAGES+1];
  logic [WIDTH-1:0] w_data  [STAGES+1];
  elastic_state_t   w_state [STAGES];
  logic [OCC_W-1:0] w_occ;

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = in_data;
  assign in_ready        = w_ready[0];
  assign out_valid       = w_valid[STAGES];
  assign out_data        = w_data[STAGES];
  assign w_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    skid_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_valid (w_valid[k]),
      .o_ready (w_ready[k]),
      .i_data  (w_data[k]),
      .o_valid (w_valid[k+1]),
      .i_ready (w_ready[k+1]),
      .o_data  (w_data[k+1]),
      .o_state (w_state[k])
    );
  end

  // Total fill level, derived only from registered stage states.
  always_comb begin
    w_occ = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_occ = w_occ + OCC_W'(state_count(w_state[k]));
    end
  end

  assign occupancy = w_occ;

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Bench for elastic_pipeline_register: a 2-stage and a 1-stage instance are
// checked against a queue-per-stage reference model, plus directed sequences.
module tb_elastic_pipeline_register;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [2:0]  e_occ;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fl2, iv2, ir2, ov2, or2;
  logic [31:0] id2, od2;
  logic [2:0]  occ2;
  logic        fl1, iv1, ir1, ov1, or1;
  logic [31:0] id1, od1;
  logic [1:0]  occ1;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: one queue (max 2 entries) per stage; index d*2+k.
  logic [31:0] mq [4][$];

  always #5 clk = ~clk;

  elastic_pipeline_register #(.WIDTH(32), .STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(fl2),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(occ2)
  );

  elastic_pipeline_register #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1)
  );

  function automatic int msz(input int d, input int k);
    return mq[d*2+k].size();
  endfunction

  function automatic int nst(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check(input int d);
    int          s;
    logic [31:0] occ;
    logic [31:0] a_ir, a_ov, a_od, a_occ;
    s   = nst(d);
    occ = 0;
    for (int k = 0; k < s; k++) occ += 32'(msz(d, k));
    if (d == 0) begin
      a_ir = 32'(ir2); a_ov = 32'(ov2); a_od = od2; a_occ = 32'(occ2);
    end else begin
      a_ir = 32'(ir1); a_ov = 32'(ov1); a_od = od1; a_occ = 32'(occ1);
    end
    chk((d == 0) ? "s2_in_ready" : "s1_in_ready", a_ir, 32'(msz(d, 0) < 2));
    chk((d == 0) ? "s2_out_valid" : "s1_out_valid", a_ov, 32'(msz(d, s-1) > 0));
    chk((d == 0) ? "s2_occupancy" : "s1_occupancy", a_occ, occ);
    if (msz(d, s-1) > 0) chk((d == 0) ? "s2_out_data" : "s1_out_data", a_od, mq[d*2+s-1][0]);
  endtask

  // One clock: drive inputs at the negedge, advance model at posedge, check at next negedge.
  task automatic step(input int d, input logic iv, input logic [31:0] id, input logic ordy,
                      input logic fl, output logic acc, output logic oxf);
    int   s;
    logic xf [3];
    s = nst(d);
    if (d == 0) begin
      iv2 = iv; id2 = id; or2 = ordy; fl2 = fl;
    end else begin
      iv1 = iv; id1 = id; or1 = ordy; fl1 = fl;
    end
    for (int k = 0; k < 3; k++) xf[k] = 1'b0;
    xf[0] = iv && (msz(d, 0) < 2);
    for (int k = 1; k < s; k++) xf[k] = (msz(d, k-1) > 0) && (msz(d, k) < 2);
    xf[s] = (msz(d, s-1) > 0) && ordy;
    acc = xf[0] && !fl;
    oxf = xf[s];
    @(posedge clk);
    if (fl) begin
      for (int k = 0; k < s; k++) mq[d*2+k].delete();
    end else begin
      if (xf[s]) void'(mq[d*2+s-1].pop_front());
      for (int k = s-1; k >= 1; k--) begin
        if (xf[k]) begin
          mq[d*2+k].push_back(mq[d*2+k-1][0]);
          void'(mq[d*2+k-1].pop_front());
        end
      end
      if (xf[0]) mq[d*2].push_back(id);
    end
    @(negedge clk);
    model_check(d);
  endtask

  initial begin
    vec_t        tbl [5];
    logic        acc, oxf, cur_iv, ordy;
    logic [31:0] w;
    int          got, sent, cyc;

    tbl[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  3'd1};
    tbl[1] = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 3'd2};
    tbl[2] = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 3'd2};
    tbl[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h33, 3'd1};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  3'd0};

    rst_n = 1'b0;
    fl2 = 1'b0; iv2 = 1'b0; id2 = '0; or2 = 1'b0;
    fl1 = 1'b0; iv1 = 1'b0; id1 = '0; or1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(ir2), 32'd1);
    chk("rst_out_valid", 32'(ov2), 32'd0);
    chk("rst_occupancy", 32'(occ2), 32'd0);
    chk("rst1_in_ready", 32'(ir1), 32'd1);
    chk("rst1_out_valid", 32'(ov1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back stream with out_ready held high.
    for (int r = 0; r < 5; r++) begin
      step(0, tbl[r].iv, tbl[r].id, tbl[r].ordy, tbl[r].fl, acc, oxf);
      chk("tbl_in_ready", 32'(ir2), 32'(tbl[r].e_ir));
      chk("tbl_out_valid", 32'(ov2), 32'(tbl[r].e_ov));
      chk("tbl_occupancy", 32'(occ2), 32'(tbl[r].e_occ));
      if (tbl[r].e_ov) chk("tbl_out_data", od2, tbl[r].e_od);
    end

    // Backpressure: four words fill the chain, the fifth is refused.
    w = 32'hA0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_in_ready", 32'(ir2), 32'd1);
      step(0, 1'b1, w, 1'b0, 1'b0, acc, oxf);
      if (acc) w++;
    end
    chk("bp_occupancy", 32'(occ2), 32'd4);
    chk("bp_full_ready", 32'(ir2), 32'd0);
    step(0, 1'b1, w, 1'b0, 1'b0, acc, oxf);
    chk("bp_still_full", 32'(ir2), 32'd0);
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (ov2) begin
        chk("bp_order", od2, 32'hA0 + 32'(got));
        got++;
      end
      cur_iv = (w <= 32'hA5);
      step(0, cur_iv, w, 1'b1, 1'b0, acc, oxf);
      if (acc) w++;
    end
    chk("bp_count", 32'(got), 32'd6);

    // Flush with three words held and a same-cycle input that must be dropped.
    for (int c = 0; c < 3; c++) step(0, 1'b1, 32'hB0 + 32'(c), 1'b0, 1'b0, acc, oxf);
    chk("fl_pre_occ", 32'(occ2), 32'd3);
    step(0, 1'b1, 32'hDEAD, 1'b0, 1'b1, acc, oxf);
    chk("fl_occupancy", 32'(occ2), 32'd0);
    chk("fl_out_valid", 32'(ov2), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step(0, 1'b0, 32'h0, 1'b1, 1'b0, acc, oxf);
      chk("fl_no_output", 32'(ov2), 32'd0);
    end

    // Random valid/ready traffic with an incrementing payload.
    sent = 0; got = 0; cyc = 0; cur_iv = 1'b0;
    while (got < 10000 && cyc < 60000) begin
      if (!cur_iv) cur_iv = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      if (ov2 && ordy) begin
        chk("rnd_scoreboard", od2, 32'h1000_0000 + 32'(got));
        got++;
      end
      step(0, cur_iv, 32'h1000_0000 + 32'(sent), ordy, 1'b0, acc, oxf);
      if (acc) begin
        sent++;
        cur_iv = 1'b0;
      end
      chk("rnd_occ_max", 32'(occ2 <= 3'd4), 32'd1);
      cyc++;
    end
    chk("rnd_budget", 32'(got >= 10000), 32'd1);
    for (int c = 0; c < 10; c++) begin
      if (ov2) begin
        chk("rnd_scoreboard", od2, 32'h1000_0000 + 32'(got));
        got++;
      end
      step(0, 1'b0, 32'h0, 1'b1, 1'b0, acc, oxf);
    end
    chk("rnd_drained", 32'(occ2), 32'd0);
    chk("rnd_no_loss", 32'(got), 32'(sent));

    // Asynchronous reset between clock edges while the chain holds data.
    for (int c = 0; c < 3; c++) step(0, 1'b1, 32'hC0 + 32'(c), 1'b0, 1'b0, acc, oxf);
    iv2 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(ov2), 32'd0);
    chk("ar_occupancy", 32'(occ2), 32'd0);
    chk("ar_in_ready", 32'(ir2), 32'd1);
    for (int k = 0; k < 4; k++) mq[k].delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b1, 32'h55, 1'b1, 1'b0, acc, oxf);
    chk("ar_latency_early", 32'(ov2), 32'd0);
    step(0, 1'b0, 32'h0, 1'b1, 1'b0, acc, oxf);
    chk("ar_latency_valid", 32'(ov2), 32'd1);
    chk("ar_first_word", od2, 32'h55);
    step(0, 1'b0, 32'h0, 1'b1, 1'b0, acc, oxf);
    chk("ar_after_word", 32'(ov2), 32'd0);

    // Single stage, out_ready toggling, continuous input.
    w = 32'hD0; got = 0;
    for (int c = 0; c < 40; c++) begin
      ordy = (c % 2 == 1);
      if (c >= 3) chk("s1_ready_pattern", 32'(ir1), 32'(c % 2 == 0));
      if (ov1 && ordy) begin
        chk("s1_order", od1, 32'hD0 + 32'(got));
        got++;
      end
      step(1, 1'b1, w, ordy, 1'b0, acc, oxf);
      if (acc) w++;
    end
    for (int c = 0; c < 4; c++) begin
      if (ov1) begin
        chk("s1_order", od1, 32'hD0 + 32'(got));
        got++;
      end
      step(1, 1'b0, 32'h0, 1'b1, 1'b0, acc, oxf);
    end
    chk("s1_exactly_once", 32'(got), w - 32'hD0);
    chk("s1_drained", 32'(occ1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
